// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial add/subtract unit.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // The bit counter never collapses to zero width, even for a 1-bit datapath.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand (upstream) and result (downstream) handshakes of the serial adder.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_cin;
  logic             i_sub;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_sum;
  logic             o_cout;
  logic             o_overflow;

  modport slave (
    input  i_valid, i_a, i_b, i_cin, i_sub, i_ready,
    output o_ready, o_valid, o_sum, o_cout, o_overflow
  );

  modport master (
    output i_valid, i_a, i_b, i_cin, i_sub, i_ready,
    input  o_ready, o_valid, o_sum, o_cout, o_overflow
  );
endinterface

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell shared by every bit position of the serial adder.
module full_adder (
  input  logic i_bit1,
  input  logic i_bit2,
  input  logic i_carry,
  output logic o_sum,
  output logic o_carry
);
  assign o_sum   = i_bit1 ^ i_bit2 ^ i_carry;
  assign o_carry = (i_bit1 & i_bit2) | (i_carry & (i_bit1 ^ i_bit2));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract unit: one full-adder cell, LSB first, valid/ready on both sides.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  serial_adder_if.slave bus
);
  localparam int CNT_W = cnt_width(WIDTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic               fa_sum;
  logic               fa_carry;
  logic               last_bit;
  logic [WIDTH:0]     sum_shift;

  full_adder u_full_adder (
    .i_bit1  (a_q[0]),
    .i_bit2  (b_q[0]),
    .i_carry (carry_q),
    .o_sum   (fa_sum),
    .o_carry (fa_carry)
  );

  assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
  // New sum bit enters at the MSB; this form stays legal when WIDTH is 1.
  assign sum_shift = {fa_sum, sum_q} >> 1;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          state_d = RUN;
          a_d     = bus.i_a;
          b_d     = bus.i_sub ? ~bus.i_b : bus.i_b;
          carry_d = bus.i_sub ? 1'b1 : bus.i_cin;
          cnt_d   = '0;
        end
      end
      RUN: begin
        sum_d   = sum_shift[WIDTH-1:0];
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_carry;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_bit) begin
          // Operand MSBs are at bit 0 of the shift registers by the final cycle.
          cout_d  = fa_carry;
          ovf_d   = (a_q[0] == b_q[0]) && (fa_sum != a_q[0]);
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.o_ready    = (state_q == IDLE);
  assign bus.o_valid    = (state_q == DONE);
  assign bus.o_sum      = sum_q;
  assign bus.o_cout     = cout_q;
  assign bus.o_overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed scoreboard bench for serial_adder at WIDTH=8, plus a WIDTH=1 instance.
module tb_serial_adder;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   edges = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  res_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) edges++;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) dut8 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus8.slave)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus1.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic done on plain integers, independent of the bit-serial datapath.
  function automatic res_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, input logic sub);
    res_t r;
    int   ua = int'(a);
    int   ub = int'(b);
    int   sa = int'($signed(a));
    int   sbv = int'($signed(b));
    int   u;
    int   s;
    if (!sub) begin
      u = ua + ub + int'(cin);
      s = sa + sbv + int'(cin);
      r.cout = (u > 255);
    end else begin
      u = ua - ub;
      s = sa - sbv;
      r.cout = (ua >= ub);
    end
    r.sum = u[7:0];
    r.ovf = (s > 127) || (s < -128);
    return r;
  endfunction

  // Called at a negedge; returns the cycle number of the accept edge.
  task automatic drive_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic sub, output int acc_cycle);
    int guard = 0;
    while (!bus8.o_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_drive", 32'(bus8.o_ready), 32'd1);
    bus8.i_a     = a;
    bus8.i_b     = b;
    bus8.i_cin   = cin;
    bus8.i_sub   = sub;
    bus8.i_valid = 1'b1;
    sb.push_back(model(a, b, cin, sub));
    acc_cycle = edges + 1;
    @(negedge clk);
    bus8.i_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, output int seen_cycle);
    int guard = 0;
    while (!bus8.o_valid && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_valid_timeout"}, 32'(bus8.o_valid), 32'd1);
    seen_cycle = edges + 1;
  endtask

  task automatic take_result(input string tag);
    res_t e;
    check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_sum"},  32'(bus8.o_sum),      32'(e.sum));
      check({tag, "_cout"}, 32'(bus8.o_cout),     32'(e.cout));
      check({tag, "_ovf"},  32'(bus8.o_overflow), 32'(e.ovf));
    end
    bus8.i_ready = 1'b1;
    @(negedge clk);
    bus8.i_ready = 1'b0;
    check({tag, "_ready_after_take"}, 32'(bus8.o_ready), 32'd1);
    check({tag, "_valid_after_take"}, 32'(bus8.o_valid), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sub);
    int acc;
    int seen;
    drive_op(a, b, cin, sub, acc);
    wait_result(tag, seen);
    take_result(tag);
  endtask

  initial begin
    int   acc;
    int   seen;
    int   guard;
    logic stable_ok;
    logic no_valid;
    res_t e;

    bus8.i_valid = 1'b0; bus8.i_a = '0; bus8.i_b = '0;
    bus8.i_cin = 1'b0; bus8.i_sub = 1'b0; bus8.i_ready = 1'b0;
    bus1.i_valid = 1'b0; bus1.i_a = '0; bus1.i_b = '0;
    bus1.i_cin = 1'b0; bus1.i_sub = 1'b0; bus1.i_ready = 1'b0;

    // Power-on reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("por_ready", 32'(bus8.o_ready), 32'd1);
    check("por_valid", 32'(bus8.o_valid), 32'd0);
    check("por_sum",   32'(bus8.o_sum),   32'h00);

    // Basic add with latency: o_valid first seen in cycle accept+WIDTH+1
    drive_op(8'h0F, 8'h01, 1'b0, 1'b0, acc);
    wait_result("add_0f_01", seen);
    check("latency_w8", 32'(seen - acc), 32'd9);
    take_result("add_0f_01");

    // Mid-idle reset clears the held result
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(bus8.o_ready),    32'd1);
    check("rst_valid", 32'(bus8.o_valid),    32'd0);
    check("rst_sum",   32'(bus8.o_sum),      32'h00);
    check("rst_cout",  32'(bus8.o_cout),     32'd0);
    check("rst_ovf",   32'(bus8.o_overflow), 32'd0);

    run_op("add_ff_01",   8'hFF, 8'h01, 1'b0, 1'b0);
    run_op("add_7f_01",   8'h7F, 8'h01, 1'b0, 1'b0);
    run_op("add_00_cin",  8'h00, 8'h00, 1'b1, 1'b0);
    run_op("sub_05_07",   8'h05, 8'h07, 1'b0, 1'b0 | 1'b1);
    run_op("sub_80_01",   8'h80, 8'h01, 1'b1, 1'b1);
    run_op("add_a5_5b_c", 8'hA5, 8'h5B, 1'b1, 1'b0);
    run_op("sub_33_33",   8'h33, 8'h33, 1'b0, 1'b1);

    // Backpressure in DONE and a stray i_valid pulse during RUN
    drive_op(8'h12, 8'h34, 1'b0, 1'b0, acc);
    @(negedge clk);
    check("run_ready_low", 32'(bus8.o_ready), 32'd0);
    bus8.i_a = 8'hFF; bus8.i_b = 8'hFF; bus8.i_sub = 1'b1; bus8.i_valid = 1'b1;
    @(negedge clk);
    bus8.i_valid = 1'b0;
    wait_result("hold", seen);
    e = sb[0];
    stable_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!(bus8.o_valid === 1'b1 && bus8.o_ready === 1'b0 && bus8.o_sum === e.sum &&
            bus8.o_cout === e.cout && bus8.o_overflow === e.ovf))
        stable_ok = 1'b0;
      @(negedge clk);
    end
    check("hold_stable", 32'(stable_ok), 32'd1);
    take_result("hold");
    no_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (bus8.o_valid !== 1'b0) no_valid = 1'b0;
      @(negedge clk);
    end
    check("no_extra_op", 32'(no_valid), 32'd1);

    // Reset during the 4th RUN cycle aborts the operation
    drive_op(8'hAA, 8'h55, 1'b0, 1'b0, acc);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_front());
    check("abort_ready", 32'(bus8.o_ready), 32'd1);
    check("abort_valid", 32'(bus8.o_valid), 32'd0);
    check("abort_sum",   32'(bus8.o_sum),   32'h00);
    no_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (bus8.o_valid !== 1'b0) no_valid = 1'b0;
      @(negedge clk);
    end
    check("abort_no_valid", 32'(no_valid), 32'd1);
    run_op("after_abort", 8'h3C, 8'h42, 1'b1, 1'b0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    // WIDTH=1 instance: 1+1 and 0-1
    bus1.i_a = 1'b1; bus1.i_b = 1'b1; bus1.i_cin = 1'b0; bus1.i_sub = 1'b0;
    bus1.i_valid = 1'b1;
    acc = edges + 1;
    @(negedge clk);
    bus1.i_valid = 1'b0;
    guard = 0;
    while (!bus1.o_valid && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check("w1_valid_timeout", 32'(bus1.o_valid), 32'd1);
    check("latency_w1", 32'(edges + 1 - acc), 32'd2);
    check("w1_add_sum",  32'(bus1.o_sum),      32'd0);
    check("w1_add_cout", 32'(bus1.o_cout),     32'd1);
    check("w1_add_ovf",  32'(bus1.o_overflow), 32'd1);
    bus1.i_ready = 1'b1;
    @(negedge clk);
    bus1.i_ready = 1'b0;
    check("w1_ready_after_take", 32'(bus1.o_ready), 32'd1);

    bus1.i_a = 1'b0; bus1.i_b = 1'b1; bus1.i_cin = 1'b1; bus1.i_sub = 1'b1;
    bus1.i_valid = 1'b1;
    @(negedge clk);
    bus1.i_valid = 1'b0;
    guard = 0;
    while (!bus1.o_valid && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check("w1_sub_valid_timeout", 32'(bus1.o_valid), 32'd1);
    check("w1_sub_sum",  32'(bus1.o_sum),      32'd1);
    check("w1_sub_cout", 32'(bus1.o_cout),     32'd0);
    check("w1_sub_ovf",  32'(bus1.o_overflow), 32'd1);
    bus1.i_ready = 1'b1;
    @(negedge clk);
    bus1.i_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
